// File: rtl/toggle_pulse_rx.sv
// toggle_pulse_rx: turns toggle-line transitions into queued valid/ready events.
// Acknowledge toggle output is built only when TOGGLE_RX_ACK_EN is defined.
module toggle_pulse_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_PEND    = 7,
   parameter int CW          = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tog_in,
   input  logic          evt_ready,
   input  logic          ovf_clr,
   output logic          evt_valid,
   output logic [CW-1:0] pend_cnt,
   output logic          ovf,
   output logic          ack_tog
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   tog_s;
   logic                   tog_d;
   logic                   edge_det;
   logic                   accept;
   logic                   full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         tog_d <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], tog_in};
         tog_d <= tog_s;
      end
   end

   assign tog_s     = sync[SYNC_STAGES-1];
   assign edge_det  = tog_s ^ tog_d;
   assign evt_valid = (pend_cnt != '0);
   assign accept    = evt_valid & evt_ready;
   assign full      = (pend_cnt == CW'(MAX_PEND));

   // An edge coinciding with an accept cancels out, so it never overflows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (edge_det && !accept && !full)
            pend_cnt <= pend_cnt + CW'(1);
         else if (accept && !edge_det)
            pend_cnt <= pend_cnt - CW'(1);

         if (edge_det && !accept && full)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

`ifdef TOGGLE_RX_ACK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ack_tog <= 1'b0;
      else if (accept)
         ack_tog <= ~ack_tog;
   end
`else
   assign ack_tog = 1'b0;
`endif

endmodule

// File: doc/toggle_pulse_rx.md
Name: toggle_pulse_rx

Overview:
- Receiving end of the toggle-signalling link: a T flip-flop transmitter inverts one line per event, and this block turns each level change back into a discrete event.
- Synchronises the asynchronous toggle line into the clk domain and detects each transition.
- Queues detected events in a saturating pending counter and presents them to a consumer through a valid/ready handshake.
- Returns an acknowledge toggle per consumed event, closing a toggle req/ack loop to the transmitter.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tog_in (legal 2..4).
- MAX_PEND, 7, maximum queued events (legal 1..255).
- CW, 3, pending-count width; must satisfy 2^CW > MAX_PEND.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- tog_in  input  1  toggle line from transmitter; asynchronous to clk.
- evt_ready  input  1  consumer can accept an event this cycle.
- ovf_clr  input  1  synchronous clear of the sticky overflow flag.
- evt_valid  output  1  at least one event pending.
- pend_cnt  output  CW  number of pending events.
- ovf  output  1  sticky flag: an event was dropped.
- ack_tog  output  1  acknowledge toggle back to transmitter.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Reset values: all synchroniser flops 0, tog_d 0, pend_cnt 0, evt_valid 0, ovf 0, ack_tog 0.
- Reset mid-operation clears all queued events immediately. No event is generated on reset release while tog_in is 0.
- tog_in is expected to be 0 at reset release, which is the transmitter's reset/initial state. If tog_in is 1 at release, exactly one event is counted.
- Synchroniser: tog_s is the last stage of the SYNC_STAGES chain; tog_d is tog_s delayed one clk.
- Edge detect: edge = tog_s XOR tog_d. Both rising and falling transitions count as one event.
- Latency: a tog_in change captured at clk edge k raises evt_valid and increments pend_cnt after edge k+SYNC_STAGES (3 edges for the default).
- Transmitter rule: consecutive toggles must be held at least 2 clk periods. Faster toggles may merge and are not detected as errors.
- accept = evt_valid AND evt_ready. evt_valid is high exactly when pend_cnt != 0. evt_valid never depends combinationally on evt_ready.
- Counter update, per cycle:
  - edge only, pend_cnt < MAX_PEND: +1.
  - edge only, pend_cnt == MAX_PEND: hold, ovf <= 1 (event dropped).
  - accept only: -1.
  - edge and accept together: hold, no overflow even when full.
  - neither: hold.
- Empty: evt_ready is ignored while pend_cnt == 0; there is no underflow.
- ovf: set as above and cleared by ovf_clr. If set and clear happen in the same cycle, set wins.
- ack_tog: inverts on the clk edge that completes each accept, giving exactly one toggle per consumed event. Back-to-back accepts toggle on consecutive cycles.

Optional Feature:
- Macro TOGGLE_RX_ACK_EN.
- Defined: ack_tog behaves as described above.
- Not defined: ack_tog is tied to 0 and its flop is not built; all other behaviour is unchanged.

Test Plan:
- Reset and latency: rst high 3 cycles; after release toggle tog_in 0->1 once with evt_ready=0 -> evt_valid rises exactly 3 edges later, pend_cnt=1, ack_tog stays 0.
- Both polarities: 4 toggles (1,0,1,0) spaced 4 cycles apart, evt_ready=0 -> pend_cnt=4, ovf=0. Then hold evt_ready=1 -> 4 accept cycles, pend_cnt reaches 0, evt_valid drops, ack_tog toggles 4 times and ends at 0.
- Overflow: 9 toggles with evt_ready=0 -> pend_cnt saturates at 7, ovf=1. Pulse ovf_clr -> ovf=0, pend_cnt still 7.
- Simultaneous events: at pend_cnt=7 with evt_ready=1, a detected edge lands on an accept cycle -> pend_cnt stays 7, ovf stays 0, ack_tog toggles.
- Reset mid-operation: pend_cnt=5, assert rst asynchronously between clk edges -> pend_cnt, evt_valid and ack_tog go to 0 immediately without waiting for a clock edge.
- Option off: compile without TOGGLE_RX_ACK_EN and rerun the drain test -> ack_tog constant 0, all counts identical to the option-on run.
